// File: rtl/fewcore_mem_pkg.sv
// Shared definitions for the load/store path.
// funct3 codes, sequencer states and request classification helpers.
package fewcore_mem_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    RESP    = 2'd3
  } state_t;

  function automatic logic f3_legal(
    input logic       write,
    input logic [2:0] f3
  );
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!write) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic bad;
    unique case (1'b1)
      (f3 == F3_H) || (f3 == F3_HU): bad = lo[0];
      (f3 == F3_W):                  bad = (lo != 2'b00);
      default:                       bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Only a full-word store can skip the read half of the sequence.
  function automatic logic needs_read(
    input logic       write,
    input logic [2:0] f3
  );
    return !(write && (f3 == F3_W));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: extract/extend for loads,
// merge of a byte or halfword into a word for stores.
module mem_lane_align
  import fewcore_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      lane,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_word
);

  logic [4:0]      sh;
  logic [7:0]      b;
  logic [15:0]     h;
  logic [XLEN-1:0] mask;

  assign sh = {lane, 3'b000};

  always_comb begin
    b = 8'(word >> sh);
    h = 16'(word >> sh);
    load_data = '0;
    case (funct3)
      F3_B:  load_data = {{(XLEN-8){b[7]}}, b};
      F3_H:  load_data = {{(XLEN-16){h[15]}}, h};
      F3_W:  load_data = word;
      F3_BU: load_data = {{(XLEN-8){1'b0}}, b};
      F3_HU: load_data = {{(XLEN-16){1'b0}}, h};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    mask = '1;
    case (funct3)
      F3_B: mask = {{(XLEN-8){1'b0}}, 8'hFF} << sh;
      F3_H: mask = {{(XLEN-16){1'b0}}, 16'hFFFF} << sh;
      default: mask = '1;
    endcase
    store_word = (word & ~mask) | ((wdata << sh) & mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between execute and data memory.
// Sub-word stores run as read-modify-write of the whole word.
module mem_access_unit
  import fewcore_mem_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_read_address,
  output logic [XLEN-1:0] mem_write_address,
  output logic [XLEN-1:0] mem_data_write,
  output logic            mem_write_enabled,
  input  logic [XLEN-1:0] mem_data_out
);

  localparam int CW =
    (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(READ_LATENCY);

  state_t          state;
  logic            r_write;
  logic [2:0]      r_f3;
  logic [1:0]      r_lane;
  logic [XLEN-1:0] r_wdata;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_word;
  logic [XLEN-1:0] word_addr;
  logic            req_bad;

  assign word_addr = {req_addr[XLEN-1:2], 2'b00};
  assign req_bad   = !f3_legal(req_write, req_funct3)
                   || misaligned(req_funct3, req_addr[1:0]);

  mem_lane_align #(
    .XLEN(XLEN)
  ) u_align (
    .word      (mem_data_out),
    .lane      (r_lane),
    .funct3    (r_f3),
    .wdata     (r_wdata),
    .load_data (load_data),
    .store_word(store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      req_ready         <= 1'b1;
      resp_valid        <= 1'b0;
      resp_err          <= 1'b0;
      resp_rdata        <= '0;
      mem_read_address  <= '0;
      mem_write_address <= '0;
      mem_data_write    <= '0;
      mem_write_enabled <= 1'b0;
      r_write           <= 1'b0;
      r_f3              <= '0;
      r_lane            <= '0;
      r_wdata           <= '0;
      cnt               <= '0;
    end else begin
      mem_write_enabled <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            r_write   <= req_write;
            r_f3      <= req_funct3;
            r_lane    <= req_addr[1:0];
            r_wdata   <= req_wdata;
            if (req_bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (!needs_read(req_write, req_funct3)) begin
              state             <= WR;
              mem_write_address <= word_addr;
              mem_data_write    <= req_wdata;
              mem_write_enabled <= 1'b1;
            end else begin
              state            <= RD_WAIT;
              mem_read_address <= word_addr;
              cnt              <= LAT;
            end
          end
        end
        RD_WAIT: begin
          // Memory word is sampled once the counter has drained.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (r_write) begin
            state             <= WR;
            mem_write_address <= mem_read_address;
            mem_data_write    <= store_word;
            mem_write_enabled <= 1'b1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end
        end
        WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised scoreboard bench for mem_access_unit,
// two instances with read latency 1 and 3.
module tb_mem_access_unit;

  localparam int NI = 2;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          start;
  } exp_t;

  typedef struct {
    int          inst;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        resp_valid[NI];
  logic        resp_ready[NI];
  logic        resp_err  [NI];
  logic [31:0] resp_rdata[NI];
  logic [31:0] mem_ra    [NI];
  logic [31:0] mem_wa    [NI];
  logic [31:0] mem_wd    [NI];
  logic        mem_we    [NI];
  logic [31:0] mem_do    [NI];

  logic [31:0] dmem[NI][64];
  logic [7:0]  mm  [NI][256];
  int          rlat[NI] = '{1, 3};
  int          hold[NI] = '{0, 0};
  logic [31:0] last_rdata[NI];
  logic        last_err  [NI];

  exp_t exp_q[$];
  wr_t  wr_q[$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] pipe[4];
    logic        pv, pr, perr;
    logic [31:0] prd;
    exp_t        e;
    wr_t         w;

    mem_access_unit #(
      .XLEN(32),
      .READ_LATENCY(L)
    ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid[g]),
      .req_ready        (req_ready[g]),
      .req_write        (req_write),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid[g]),
      .resp_ready       (resp_ready[g]),
      .resp_rdata       (resp_rdata[g]),
      .resp_err         (resp_err[g]),
      .mem_read_address (mem_ra[g]),
      .mem_write_address(mem_wa[g]),
      .mem_data_write   (mem_wd[g]),
      .mem_write_enabled(mem_we[g]),
      .mem_data_out     (mem_do[g])
    );

    // Word memory whose read data trails the address by L cycles.
    always @(posedge clk) begin
      if (mem_we[g]) dmem[g][mem_wa[g][7:2]] = mem_wd[g];
      for (int i = 3; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= dmem[g][mem_ra[g][7:2]];
    end
    assign mem_do[g] = pipe[L-1];

    always @(negedge clk) begin
      if (!rst_n) begin
        pv = 1'b0;
        pr = 1'b0;
        resp_ready[g] = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("hold_valid", 32'(resp_valid[g]), 32'd1);
          chk("hold_rdata", resp_rdata[g], prd);
          chk("hold_err", 32'(resp_err[g]), 32'(perr));
        end
        if (pv && pr) chk("no_b2b", 32'(resp_valid[g]), 32'd0);
        if (resp_valid[g] && !pv) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_resp");
          end else begin
            e = exp_q.pop_front();
            chk("resp_inst", 32'(g), 32'(e.inst));
            chk("resp_rdata", resp_rdata[g], e.rdata);
            chk("resp_err", 32'(resp_err[g]), 32'(e.err));
            chk("resp_latency", 32'(cyc - e.start), 32'(e.lat));
            last_rdata[g] = resp_rdata[g];
            last_err[g]   = resp_err[g];
          end
        end
        if (mem_we[g]) begin
          if (wr_q.size() == 0) begin
            fail_now("unexpected_write");
          end else begin
            w = wr_q.pop_front();
            chk("wr_inst", 32'(g), 32'(w.inst));
            chk("wr_addr", mem_wa[g], w.addr);
            chk("wr_data", mem_wd[g], w.data);
          end
        end
        if (hold[g] > 0 && resp_valid[g]) begin
          resp_ready[g] = 1'b0;
          hold[g]--;
        end else begin
          resp_ready[g] = ($urandom_range(0, 2) != 0);
        end
        pv   = resp_valid[g];
        pr   = resp_ready[g];
        prd  = resp_rdata[g];
        perr = resp_err[g];
      end
    end
  end

  function automatic logic [31:0] model_word(input int g, input int idx);
    return {mm[g][4*idx+3], mm[g][4*idx+2], mm[g][4*idx+1], mm[g][4*idx]};
  endfunction

  // Reference: byte-addressed memory, arithmetic sign extension.
  task automatic model(input int g, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       output exp_t e, output logic dow,
                       output logic [31:0] wd);
    int     size;
    int     lo;
    logic   legal;
    longint v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = wr ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
               : (f3 == F3_B || f3 == F3_H || f3 == F3_W ||
                  f3 == F3_BU || f3 == F3_HU);
    if (f3[1:0] == 2'd3) legal = 1'b0;
    lo      = int'(a[7:0]);
    e.inst  = g;
    e.rdata = '0;
    e.err   = 1'b0;
    dow     = 1'b0;
    wd      = '0;
    if (!legal || (lo % size) != 0) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (!wr) begin
      v = 0;
      for (int i = 0; i < size; i++)
        v = v + (longint'(mm[g][lo+i]) << (8*i));
      if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size-1)))
        v = v - (longint'(1) << (8*size));
      e.rdata = 32'(v);
      e.lat   = rlat[g] + 2;
    end else begin
      for (int i = 0; i < size; i++) mm[g][lo+i] = d[8*i +: 8];
      dow   = 1'b1;
      wd    = model_word(g, lo / 4);
      e.lat = (size == 4) ? 2 : rlat[g] + 3;
    end
  endtask

  task automatic issue(input int g, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic        dow;
    logic [31:0] wd;
    wr_t         w;
    int          t;
    model(g, wr, f3, a, d, e, dow, wd);
    req_write    = wr;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = d;
    req_valid[g] = 1'b1;
    t = 0;
    while (!req_ready[g] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail_now("accept_timeout");
    e.start = cyc;
    exp_q.push_back(e);
    if (dow) begin
      w.inst = g;
      w.addr = {a[31:2], 2'b00};
      w.data = wd;
      wr_q.push_back(w);
    end
    @(negedge clk);
    req_valid[g] = 1'b0;
    req_write    = 1'($urandom_range(0, 1));
    req_funct3   = 3'($urandom_range(0, 7));
    req_addr     = $urandom;
    req_wdata    = $urandom;
    t = 0;
    while ((exp_q.size() != 0 || !req_ready[g]) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail_now("resp_timeout");
  endtask

  task automatic check_reset(input int g);
    chk("rst_req_ready", 32'(req_ready[g]), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid[g]), 32'd0);
    chk("rst_resp_err", 32'(resp_err[g]), 32'd0);
    chk("rst_resp_rdata", resp_rdata[g], 32'd0);
    chk("rst_rd_addr", mem_ra[g], 32'd0);
    chk("rst_wr_addr", mem_wa[g], 32'd0);
    chk("rst_wr_data", mem_wd[g], 32'd0);
    chk("rst_wr_en", 32'(mem_we[g]), 32'd0);
  endtask

  task automatic random_ops(input int g, input int n);
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 4) == 0) hold[g] = $urandom_range(1, 4);
      issue(g, wr, f3, a, $urandom);
    end
  endtask

  task automatic directed_loads(input int g);
    issue(g, 1'b0, F3_B, 32'h20, $urandom);
    chk("lb_20", last_rdata[g], 32'hFFFFFFFF);
    issue(g, 1'b0, F3_BU, 32'h20, $urandom);
    chk("lbu_20", last_rdata[g], 32'h000000FF);
    issue(g, 1'b0, F3_H, 32'h22, $urandom);
    chk("lh_22", last_rdata[g], 32'hFFFF8000);
    issue(g, 1'b0, F3_HU, 32'h22, $urandom);
    chk("lhu_22", last_rdata[g], 32'h00008000);
    hold[g] = 4;
    issue(g, 1'b0, F3_W, 32'h20, $urandom);
    chk("lw_20_held", last_rdata[g], 32'h8000F0FF);
  endtask

  logic [31:0] saved;

  initial begin
    rst_n      = 1'b0;
    req_write  = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    for (int g = 0; g < NI; g++) begin
      req_valid[g] = 1'b0;
      for (int i = 0; i < 64; i++) begin
        saved = (i == 8) ? 32'h8000F0FF : $urandom;
        dmem[g][i] = saved;
        for (int b = 0; b < 4; b++) mm[g][4*i+b] = saved[8*b +: 8];
      end
    end
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;
    chk("ready_after_release", 32'(req_ready[0]), 32'd1);

    issue(0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    chk("sw_mem", dmem[0][4], 32'hDEADBEEF);
    chk("sw_rdata", last_rdata[0], 32'd0);
    chk("sw_err", 32'(last_err[0]), 32'd0);
    issue(0, 1'b1, F3_B, 32'h11, 32'h00000055);
    chk("sb_mem", dmem[0][4], 32'hDEAD55EF);
    issue(0, 1'b0, F3_B, 32'h11, $urandom);
    chk("lb_11", last_rdata[0], 32'h00000055);
    directed_loads(0);
    issue(0, 1'b0, F3_W, 32'h13, $urandom);
    chk("lw_13_err", 32'(last_err[0]), 32'd1);
    issue(0, 1'b1, F3_H, 32'h15, 32'h1234ABCD);
    chk("sh_15_err", 32'(last_err[0]), 32'd1);
    random_ops(0, 60);

    directed_loads(1);
    issue(1, 1'b1, F3_H, 32'h32, $urandom);
    issue(1, 1'b0, F3_W, 32'h30, $urandom);
    random_ops(1, 60);

    // Abort a byte store while it waits on its read.
    saved = model_word(1, 16);
    @(negedge clk);
    req_write    = 1'b1;
    req_funct3   = F3_B;
    req_addr     = 32'h41;
    req_wdata    = 32'hA5;
    req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset(1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_write", dmem[1][16], saved);
    issue(1, 1'b0, F3_W, 32'h40, $urandom);
    chk("abort_readback", last_rdata[1], saved);

    for (int g = 0; g < NI; g++)
      for (int i = 0; i < 64; i++)
        chk("final_mem", dmem[g][i], model_word(g, i));

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end expected end");
    $fatal(1, "watchdog");
  end

endmodule
